// File: rtl/axi_rd_arbiter_2m.sv
// Two-master AXI3 read arbiter: round-robin grant of one burst at a time onto a
// single slave read port, with R beats routed back to the granted master and a
// sticky flag for RLAST/ARLEN disagreement.
module axi_rd_arbiter_2m #(
  parameter int unsigned AXI_DW = 64,
  parameter int unsigned AXI_AW = 32,
  parameter int unsigned AXI_IW = 8
) (
  input  logic              axi_clk_i,
  input  logic              axi_rst_i,
  // master 0 AR
  input  logic [AXI_IW-1:0] m0_arid_i,
  input  logic [AXI_AW-1:0] m0_araddr_i,
  input  logic [3:0]        m0_arlen_i,
  input  logic [2:0]        m0_arsize_i,
  input  logic [1:0]        m0_arburst_i,
  input  logic [1:0]        m0_arlock_i,
  input  logic [3:0]        m0_arcache_i,
  input  logic [2:0]        m0_arprot_i,
  input  logic              m0_arvalid_i,
  output logic              m0_arready_o,
  // master 0 R
  output logic [AXI_IW-1:0] m0_rid_o,
  output logic [AXI_DW-1:0] m0_rdata_o,
  output logic [1:0]        m0_rresp_o,
  output logic              m0_rlast_o,
  output logic              m0_rvalid_o,
  input  logic              m0_rready_i,
  // master 1 AR
  input  logic [AXI_IW-1:0] m1_arid_i,
  input  logic [AXI_AW-1:0] m1_araddr_i,
  input  logic [3:0]        m1_arlen_i,
  input  logic [2:0]        m1_arsize_i,
  input  logic [1:0]        m1_arburst_i,
  input  logic [1:0]        m1_arlock_i,
  input  logic [3:0]        m1_arcache_i,
  input  logic [2:0]        m1_arprot_i,
  input  logic              m1_arvalid_i,
  output logic              m1_arready_o,
  // master 1 R
  output logic [AXI_IW-1:0] m1_rid_o,
  output logic [AXI_DW-1:0] m1_rdata_o,
  output logic [1:0]        m1_rresp_o,
  output logic              m1_rlast_o,
  output logic              m1_rvalid_o,
  input  logic              m1_rready_i,
  // slave AR
  output logic [AXI_IW-1:0] s_arid_o,
  output logic [AXI_AW-1:0] s_araddr_o,
  output logic [3:0]        s_arlen_o,
  output logic [2:0]        s_arsize_o,
  output logic [1:0]        s_arburst_o,
  output logic [1:0]        s_arlock_o,
  output logic [3:0]        s_arcache_o,
  output logic [2:0]        s_arprot_o,
  output logic              s_arvalid_o,
  input  logic              s_arready_i,
  // slave R
  input  logic [AXI_IW-1:0] s_rid_i,
  input  logic [AXI_DW-1:0] s_rdata_i,
  input  logic [1:0]        s_rresp_i,
  input  logic              s_rlast_i,
  input  logic              s_rvalid_i,
  output logic              s_rready_o,
  // status
  output logic              grant_o,
  output logic              busy_o,
  output logic              len_err_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                grant_q, grant_d;
  logic [3:0]          beat_cnt_q, beat_cnt_d;
  logic                len_err_q, len_err_d;
  logic [AXI_IW-1:0]   arid_q, arid_d;
  logic [AXI_AW-1:0]   araddr_q, araddr_d;
  logic [3:0]          arlen_q, arlen_d;
  logic [2:0]          arsize_q, arsize_d;
  logic [1:0]          arburst_q, arburst_d;
  logic [1:0]          arlock_q, arlock_d;
  logic [3:0]          arcache_q, arcache_d;
  logic [2:0]          arprot_q, arprot_d;
  logic                win;
  logic                beat;

  // State and captured AR fields; reset drops any burst in flight.
  always_ff @(posedge axi_clk_i) begin
    if (axi_rst_i) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      beat_cnt_q   <= 4'd0;
      len_err_q    <= 1'b0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= 4'd0;
      arsize_q     <= 3'd0;
      arburst_q    <= 2'd0;
      arlock_q     <= 2'd0;
      arcache_q    <= 4'd0;
      arprot_q     <= 3'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      beat_cnt_q   <= beat_cnt_d;
      len_err_q    <= len_err_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arlock_q     <= arlock_d;
      arcache_q    <= arcache_d;
      arprot_q     <= arprot_d;
    end
  end

  // Next-state: arbitration and AR accept in IDLE, handshake in ADDR, beat checking in DATA.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    beat_cnt_d   = beat_cnt_q;
    len_err_d    = len_err_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arlock_d     = arlock_q;
    arcache_d    = arcache_q;
    arprot_d     = arprot_q;
    m0_arready_o = 1'b0;
    m1_arready_o = 1'b0;
    // on a tie the master that did not win last time goes next
    win          = (m0_arvalid_i && m1_arvalid_i) ? ~last_grant_q : m1_arvalid_i;
    beat         = s_rvalid_i && s_rready_o;

    unique case (state_q)
      ST_IDLE: begin
        if (m0_arvalid_i || m1_arvalid_i) begin
          last_grant_d = win;
          grant_d      = win;
          state_d      = ST_ADDR;
          if (win) begin
            m1_arready_o = 1'b1;
            arid_d       = m1_arid_i;
            araddr_d     = m1_araddr_i;
            arlen_d      = m1_arlen_i;
            arsize_d     = m1_arsize_i;
            arburst_d    = m1_arburst_i;
            arlock_d     = m1_arlock_i;
            arcache_d    = m1_arcache_i;
            arprot_d     = m1_arprot_i;
          end else begin
            m0_arready_o = 1'b1;
            arid_d       = m0_arid_i;
            araddr_d     = m0_araddr_i;
            arlen_d      = m0_arlen_i;
            arsize_d     = m0_arsize_i;
            arburst_d    = m0_arburst_i;
            arlock_d     = m0_arlock_i;
            arcache_d    = m0_arcache_i;
            arprot_d     = m0_arprot_i;
          end
        end
      end
      ST_ADDR: begin
        if (s_arready_i) begin
          beat_cnt_d = 4'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + 4'd1;
          if ((s_rlast_i && (beat_cnt_q != arlen_q)) ||
              (!s_rlast_i && (beat_cnt_q == arlen_q))) begin
            len_err_d = 1'b1;
          end
          if (s_rlast_i) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // R path: combinational steer of the slave read channel to the granted master.
  always_comb begin
    s_rready_o  = 1'b0;
    m0_rid_o    = '0;
    m0_rdata_o  = '0;
    m0_rresp_o  = 2'd0;
    m0_rlast_o  = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rid_o    = '0;
    m1_rdata_o  = '0;
    m1_rresp_o  = 2'd0;
    m1_rlast_o  = 1'b0;
    m1_rvalid_o = 1'b0;
    if (state_q == ST_DATA) begin
      if (grant_q) begin
        s_rready_o  = m1_rready_i;
        m1_rid_o    = s_rid_i;
        m1_rdata_o  = s_rdata_i;
        m1_rresp_o  = s_rresp_i;
        m1_rlast_o  = s_rlast_i;
        m1_rvalid_o = s_rvalid_i;
      end else begin
        s_rready_o  = m0_rready_i;
        m0_rid_o    = s_rid_i;
        m0_rdata_o  = s_rdata_i;
        m0_rresp_o  = s_rresp_i;
        m0_rlast_o  = s_rlast_i;
        m0_rvalid_o = s_rvalid_i;
      end
    end
  end

  assign s_arid_o    = arid_q;
  assign s_araddr_o  = araddr_q;
  assign s_arlen_o   = arlen_q;
  assign s_arsize_o  = arsize_q;
  assign s_arburst_o = arburst_q;
  assign s_arlock_o  = arlock_q;
  assign s_arcache_o = arcache_q;
  assign s_arprot_o  = arprot_q;
  assign s_arvalid_o = (state_q == ST_ADDR);
  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign len_err_o   = len_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter_2m.sv
// Directed bench for axi_rd_arbiter_2m: grant order, AR hold, R routing,
// backpressure, length error and mid-burst reset.
module tb_axi_rd_arbiter_2m;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  m0_arid = 8'd0, m1_arid = 8'd0;
  logic [31:0] m0_araddr = '0, m1_araddr = '0;
  logic [3:0]  m0_arlen = '0, m1_arlen = '0;
  logic        m0_arvalid = 1'b0, m1_arvalid = 1'b0;
  logic        m0_arready, m1_arready;
  logic [7:0]  m0_rid, m1_rid;
  logic [63:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid;
  logic        m0_rready = 1'b0, m1_rready = 1'b0;
  logic [7:0]  s_arid;
  logic [31:0] s_araddr;
  logic [3:0]  s_arlen, s_arcache;
  logic [2:0]  s_arsize, s_arprot;
  logic [1:0]  s_arburst, s_arlock;
  logic        s_arvalid;
  logic        s_arready = 1'b0;
  logic [7:0]  s_rid = 8'h5A;
  logic [63:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'd0;
  logic        s_rlast = 1'b0, s_rvalid = 1'b0;
  logic        s_rready, grant, busy, len_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter_2m dut (
    .axi_clk_i(clk), .axi_rst_i(rst),
    .m0_arid_i(m0_arid), .m0_araddr_i(m0_araddr), .m0_arlen_i(m0_arlen),
    .m0_arsize_i(3'd3), .m0_arburst_i(2'd1), .m0_arlock_i(2'd0),
    .m0_arcache_i(4'd3), .m0_arprot_i(3'd2), .m0_arvalid_i(m0_arvalid),
    .m0_arready_o(m0_arready), .m0_rid_o(m0_rid), .m0_rdata_o(m0_rdata),
    .m0_rresp_o(m0_rresp), .m0_rlast_o(m0_rlast), .m0_rvalid_o(m0_rvalid),
    .m0_rready_i(m0_rready),
    .m1_arid_i(m1_arid), .m1_araddr_i(m1_araddr), .m1_arlen_i(m1_arlen),
    .m1_arsize_i(3'd2), .m1_arburst_i(2'd1), .m1_arlock_i(2'd0),
    .m1_arcache_i(4'd3), .m1_arprot_i(3'd0), .m1_arvalid_i(m1_arvalid),
    .m1_arready_o(m1_arready), .m1_rid_o(m1_rid), .m1_rdata_o(m1_rdata),
    .m1_rresp_o(m1_rresp), .m1_rlast_o(m1_rlast), .m1_rvalid_o(m1_rvalid),
    .m1_rready_i(m1_rready),
    .s_arid_o(s_arid), .s_araddr_o(s_araddr), .s_arlen_o(s_arlen),
    .s_arsize_o(s_arsize), .s_arburst_o(s_arburst), .s_arlock_o(s_arlock),
    .s_arcache_o(s_arcache), .s_arprot_o(s_arprot), .s_arvalid_o(s_arvalid),
    .s_arready_i(s_arready),
    .s_rid_i(s_rid), .s_rdata_i(s_rdata), .s_rresp_i(s_rresp),
    .s_rlast_i(s_rlast), .s_rvalid_i(s_rvalid), .s_rready_o(s_rready),
    .grant_o(grant), .busy_o(busy), .len_err_o(len_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ar(input int m, input logic [31:0] addr, input logic [3:0] len);
    if (m == 0) begin
      m0_arid = 8'hA0; m0_araddr = addr; m0_arlen = len; m0_arvalid = 1'b1;
    end else begin
      m1_arid = 8'hA1; m1_araddr = addr; m1_arlen = len; m1_arvalid = 1'b1;
    end
  endtask

  // In IDLE: expect master w to win; advance into ADDR and check the slave AR.
  task automatic grant_to(input int w, input logic [31:0] addr, input logic [3:0] len);
    #1;
    chk("arready_m0", 64'(m0_arready), 64'(w == 0));
    chk("arready_m1", 64'(m1_arready), 64'(w == 1));
    tick();
    if (w == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
    #1;
    chk("grant", 64'(grant), 64'(w));
    chk("s_arvalid", 64'(s_arvalid), 64'd1);
    chk("s_araddr", 64'(s_araddr), 64'(addr));
    chk("s_arlen", 64'(s_arlen), 64'(len));
    chk("s_arid", 64'(s_arid), (w == 0) ? 64'hA0 : 64'hA1);
  endtask

  // From ADDR: accept AR, then deliver nbeats with RLAST on beat last_at.
  task automatic serve(input int m, input int nbeats, input int last_at);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    if (m == 0) m0_rready = 1'b1; else m1_rready = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      s_rvalid = 1'b1;
      s_rdata  = 64'hD000 + 64'(i) + 64'(m * 256);
      s_rlast  = (i == last_at);
      #1;
      chk("rvalid_granted", 64'(m == 0 ? m0_rvalid : m1_rvalid), 64'd1);
      chk("rdata_granted", m == 0 ? m0_rdata : m1_rdata, 64'hD000 + 64'(i) + 64'(m * 256));
      chk("rvalid_other", 64'(m == 0 ? m1_rvalid : m0_rvalid), 64'd0);
      chk("arready_in_data", 64'({m0_arready, m1_arready}), 64'd0);
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    m0_rready = 1'b0; m1_rready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    // reset state
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("rst_s_araddr", 64'(s_araddr), 64'd0);
    chk("rst_s_rready", 64'(s_rready), 64'd0);

    // 1: m0 alone, 4-beat burst
    set_ar(0, 32'h100, 4'd3);
    grant_to(0, 32'h100, 4'd3);
    chk("s_arsize", 64'(s_arsize), 64'd3);
    chk("s_arprot", 64'(s_arprot), 64'd2);
    chk("busy_addr", 64'(busy), 64'd1);
    serve(0, 4, 3);
    chk("t1_busy", 64'(busy), 64'd0);
    chk("t1_len_err", 64'(len_err), 64'd0);

    // 2: contention after reset alternates m0, m1, m0, m1
    do_reset();
    set_ar(0, 32'h300, 4'd0);
    set_ar(1, 32'h400, 4'd0);
    grant_to(0, 32'h300, 4'd0);
    serve(0, 1, 0);
    grant_to(1, 32'h400, 4'd0);
    serve(1, 1, 0);
    set_ar(0, 32'h500, 4'd0);
    set_ar(1, 32'h600, 4'd0);
    grant_to(0, 32'h500, 4'd0);
    serve(0, 1, 0);
    grant_to(1, 32'h600, 4'd0);
    serve(1, 1, 0);

    // 3: slave stalls AR for 5 cycles while m1 is waiting
    set_ar(0, 32'h2000, 4'd0);
    grant_to(0, 32'h2000, 4'd0);
    set_ar(1, 32'h3000, 4'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_araddr", 64'(s_araddr), 64'h2000);
      chk("t3_arvalid", 64'(s_arvalid), 64'd1);
      chk("t3_arready", 64'({m0_arready, m1_arready}), 64'd0);
      chk("t3_busy", 64'(busy), 64'd1);
      tick();
    end
    serve(0, 1, 0);

    // 4: m1 two beats with rready 1,0,1
    grant_to(1, 32'h3000, 4'd1);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'hB0; s_rlast = 1'b0; m1_rready = 1'b1;
    #1;
    chk("t4_rready_a", 64'(s_rready), 64'd1);
    chk("t4_rdata_a", m1_rdata, 64'hB0);
    chk("t4_rid_a", 64'(m1_rid), 64'h5A);
    tick();
    s_rdata = 64'hB1; s_rlast = 1'b1; m1_rready = 1'b0;
    #1;
    chk("t4_rready_b", 64'(s_rready), 64'd0);
    chk("t4_rvalid_b", 64'(m1_rvalid), 64'd1);
    tick();
    m1_rready = 1'b1;
    #1;
    chk("t4_rready_c", 64'(s_rready), 64'd1);
    chk("t4_rlast_c", 64'(m1_rlast), 64'd1);
    chk("t4_busy_c", 64'(busy), 64'd1);
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0; m1_rready = 1'b0;
    #1;
    chk("t4_busy_end", 64'(busy), 64'd0);
    chk("t4_len_err", 64'(len_err), 64'd0);

    // 5: early RLAST on beat 2 of a 4-beat burst
    set_ar(0, 32'h5000, 4'd3);
    grant_to(0, 32'h5000, 4'd3);
    serve(0, 2, 1);
    chk("t5_len_err", 64'(len_err), 64'd1);
    chk("t5_busy", 64'(busy), 64'd0);
    set_ar(1, 32'h6000, 4'd0);
    grant_to(1, 32'h6000, 4'd0);
    serve(1, 1, 0);
    chk("t5_sticky", 64'(len_err), 64'd1);
    chk("t5_busy_end", 64'(busy), 64'd0);

    // 6: reset in DATA, then a lone m1 request is granted, then a tie goes to m0
    set_ar(0, 32'h7000, 4'd3);
    grant_to(0, 32'h7000, 4'd3);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'hC0; m0_rready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_len_err", 64'(len_err), 64'd0);
    chk("t6_s_arvalid", 64'(s_arvalid), 64'd0);
    chk("t6_s_araddr", 64'(s_araddr), 64'd0);
    chk("t6_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("t6_s_rready", 64'(s_rready), 64'd0);
    rst = 1'b0; s_rvalid = 1'b0; m0_rready = 1'b0;
    set_ar(1, 32'h8000, 4'd0);
    grant_to(1, 32'h8000, 4'd0);
    serve(1, 1, 0);
    set_ar(0, 32'h9000, 4'd0);
    set_ar(1, 32'hA000, 4'd0);
    grant_to(0, 32'h9000, 4'd0);
    serve(0, 1, 0);
    grant_to(1, 32'hA000, 4'd0);
    serve(1, 1, 0);
    #1;
    chk("t6_busy_end", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
